// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
    logic reg_write;
  } exmem_ctrl_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, registered synchronous read.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, branch resolve, data memory access, MEM/WB register.
// Define MEM_STAGE_PERF_CNT_EN to build the load/store performance counters.
module mem_stage #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic              Zero,
  input  logic [DATA_W-1:0] branch_add,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        rd,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic [4:0]        exmem_rd,
  output logic              exmem_RegWrite,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [4:0]        wb_rd,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic              misalign_err,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count
);

  import mem_stage_pkg::*;

  exmem_ctrl_t       ex_ctrl;
  exmem_ctrl_t       exmem_ctrl;
  logic              exmem_valid;
  logic              exmem_zero;
  logic [DATA_W-1:0] exmem_wdata;
  logic              misaligned;
  logic              mem_we;

  assign ex_ctrl = '{mem_read:   MemRead,
                     mem_write:  MemWrite,
                     branch:     Branch,
                     mem_to_reg: MemtoReg,
                     reg_write:  RegWrite};

  // EX/MEM register; flush wins over stall and kills valid plus all controls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exmem_valid      <= 1'b0;
      exmem_ctrl       <= '0;
      exmem_zero       <= 1'b0;
      exmem_alu_result <= '0;
      branch_target    <= '0;
      exmem_wdata      <= '0;
      exmem_rd         <= '0;
    end else if (flush || !stall) begin
      exmem_valid      <= ex_valid & ~flush;
      exmem_ctrl       <= flush ? exmem_ctrl_t'('0) : ex_ctrl;
      exmem_zero       <= Zero;
      exmem_alu_result <= ALU_result;
      branch_target    <= branch_add;
      exmem_wdata      <= write_data;
      exmem_rd         <= rd;
    end
  end

  assign pcsrc          = exmem_valid & exmem_ctrl.branch & exmem_zero;
  assign exmem_RegWrite = exmem_valid & exmem_ctrl.reg_write;

  assign misaligned = exmem_valid & (exmem_ctrl.mem_read | exmem_ctrl.mem_write)
                    & (exmem_alu_result[1:0] != 2'b00);
  assign mem_we     = ~stall & exmem_valid & exmem_ctrl.mem_write & ~misaligned;

  data_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_data_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we),
    .re      (~stall),
    .addr    (exmem_alu_result[DEPTH_LOG2+1:2]),
    .wdata   (exmem_wdata),
    .rdata   (wb_read_data)
  );

  // MEM/WB register; read data is registered inside data_mem on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      misalign_err  <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= exmem_valid;
      wb_alu_result <= exmem_alu_result;
      wb_rd         <= exmem_rd;
      wb_RegWrite   <= exmem_valid & exmem_ctrl.reg_write & ~misaligned;
      wb_MemtoReg   <= exmem_ctrl.mem_to_reg;
      misalign_err  <= misaligned;
    end
  end

`ifdef MEM_STAGE_PERF_CNT_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;

  // Count only accesses that actually leave MEM aligned and valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (!stall && exmem_valid && !misaligned) begin
      if (exmem_ctrl.mem_read)  load_cnt_q  <= load_cnt_q + 32'd1;
      if (exmem_ctrl.mem_write) store_cnt_q <= store_cnt_q + 32'd1;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`else
  assign load_count  = '0;
  assign store_count = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM/WB results, a monitor pops and compares.
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ALU_result;
  logic        Zero;
  logic [31:0] branch_add;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic        MemRead, MemWrite, Branch, MemtoReg, RegWrite;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic [4:0]  exmem_rd;
  logic        exmem_RegWrite;
  logic [31:0] exmem_alu_result;
  logic        wb_valid;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite, wb_MemtoReg;
  logic        misalign_err;
  logic [31:0] load_count, store_count;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ALU_result(ALU_result), .Zero(Zero), .branch_add(branch_add), .write_data(write_data),
    .rd(rd), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .pcsrc(pcsrc), .branch_target(branch_target), .exmem_rd(exmem_rd),
    .exmem_RegWrite(exmem_RegWrite), .exmem_alu_result(exmem_alu_result), .wb_valid(wb_valid),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .misalign_err(misalign_err),
    .load_count(load_count), .store_count(store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        regwrite;
    logic        memtoreg;
    logic        mis;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   adv_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every MEM-advancing edge retires the scoreboard entry due on that edge.
  always @(posedge clk) begin
    if (reset_n && !stall) begin
      adv_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].due < adv_cnt) begin
        chk("sb_stale_due", 32'(sb[0].due), 32'(adv_cnt));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == adv_cnt) begin
        mon_e = sb.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'(mon_e.valid));
        chk("wb_RegWrite", 32'(wb_RegWrite), 32'(mon_e.regwrite));
        chk("misalign_err", 32'(misalign_err), 32'(mon_e.mis));
        if (mon_e.valid) begin
          chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
          chk("wb_alu_result", wb_alu_result, mon_e.alu);
          chk("wb_MemtoReg", 32'(wb_MemtoReg), 32'(mon_e.memtoreg));
          if (mon_e.memtoreg) chk("wb_read_data", wb_read_data, mon_e.rdata);
        end
      end
    end
  end

  task automatic issue(input logic v, input logic fl, input logic [31:0] alu, input logic z,
                       input logic [31:0] badd, input logic [31:0] wd, input logic [4:0] r,
                       input logic mr, input logic mw, input logic br, input logic m2r,
                       input logic rw, input logic [31:0] exp_rdata);
    exp_t e;
    @(negedge clk);
    stall = 1'b0; flush = fl; ex_valid = v; ALU_result = alu; Zero = z;
    branch_add = badd; write_data = wd; rd = r;
    MemRead = mr; MemWrite = mw; Branch = br; MemtoReg = m2r; RegWrite = rw;
    e.valid    = v & ~fl;
    e.mis      = e.valid & (mr | mw) & (alu[1:0] != 2'b00);
    e.regwrite = e.valid & rw & ~e.mis;
    e.rd       = r;
    e.alu      = alu;
    e.memtoreg = m2r;
    e.rdata    = exp_rdata;
    e.due      = adv_cnt + 2;
    sb.push_back(e);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic fl, input logic rw);
    issue(1'b1, fl, a, 1'b0, 32'h0, d, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, rw, 32'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r, input logic [31:0] exp_d);
    issue(1'b1, 1'b0, a, 1'b0, 32'h0, 32'h0, r, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, exp_d);
  endtask

  task automatic alu_op(input logic [4:0] r, input logic [31:0] val);
    issue(1'b1, 1'b0, val, 1'b0, 32'h0, 32'h0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic branch(input logic z, input logic [31:0] tgt, input logic fl);
    issue(1'b1, fl, 32'h0, z, tgt, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk_branch(input logic exp_pc, input logic [31:0] exp_tgt, input logic chk_tgt);
    @(posedge clk); #1;
    chk("pcsrc", 32'(pcsrc), 32'(exp_pc));
    if (chk_tgt) chk("branch_target", branch_target, exp_tgt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pcsrc"}, 32'(pcsrc), 32'h0);
    chk({tag, "_branch_target"}, branch_target, 32'h0);
    chk({tag, "_exmem_rd"}, 32'(exmem_rd), 32'h0);
    chk({tag, "_exmem_RegWrite"}, 32'(exmem_RegWrite), 32'h0);
    chk({tag, "_exmem_alu_result"}, exmem_alu_result, 32'h0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'h0);
    chk({tag, "_wb_read_data"}, wb_read_data, 32'h0);
    chk({tag, "_wb_alu_result"}, wb_alu_result, 32'h0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'h0);
    chk({tag, "_wb_RegWrite"}, 32'(wb_RegWrite), 32'h0);
    chk({tag, "_wb_MemtoReg"}, 32'(wb_MemtoReg), 32'h0);
    chk({tag, "_misalign_err"}, 32'(misalign_err), 32'h0);
    chk({tag, "_load_count"}, load_count, 32'h0);
    chk({tag, "_store_count"}, store_count, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    ALU_result = '0; Zero = 1'b0; branch_add = '0; write_data = '0; rd = '0;
    MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Store then immediate load of the same word.
    store(32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    load(32'h10, 5'd5, 32'hDEADBEEF);
    // Flushed store and misaligned store must leave 0x20 untouched.
    store(32'h20, 32'hAAAA5555, 1'b0, 1'b0);
    store(32'h20, 32'h00001234, 1'b1, 1'b0);
    store(32'h22, 32'h00005555, 1'b0, 1'b1);
    load(32'h20, 5'd6, 32'hAAAA5555);

    branch(1'b1, 32'h40, 1'b0);
    chk_branch(1'b1, 32'h40, 1'b1);
    branch(1'b0, 32'h80, 1'b0);
    chk_branch(1'b0, 32'h80, 1'b1);
    alu_op(5'd7, 32'h1357);
    branch(1'b1, 32'hC0, 1'b1);
    chk_branch(1'b0, 32'h0, 1'b0);

    // Three stalled edges with a load in EX/MEM and an ALU op in MEM/WB.
    alu_op(5'd8, 32'h100);
    load(32'h10, 5'd9, 32'hDEADBEEF);
    @(negedge clk);
    stall = 1'b1; ex_valid = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_exmem_rd", 32'(exmem_rd), 32'd9);
      chk("stall_exmem_alu_result", exmem_alu_result, 32'h10);
      chk("stall_exmem_RegWrite", 32'(exmem_RegWrite), 32'h1);
      chk("stall_wb_rd", 32'(wb_rd), 32'd8);
      chk("stall_wb_alu_result", wb_alu_result, 32'h100);
    end
    store(32'h10, 32'hCAFEF00D, 1'b0, 1'b0);
    load(32'h10, 5'd10, 32'hCAFEF00D);
    idle();
    idle();

    // Reset asserted between edges while stalled.
    load(32'h10, 5'd11, 32'hCAFEF00D);
    @(negedge clk);
    stall = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1; stall = 1'b0;

    // Counter window after reset: 3 loads, 2 stores.
    store(32'h40, 32'h11, 1'b0, 1'b0);
    store(32'h44, 32'h22, 1'b0, 1'b0);
    load(32'h40, 5'd1, 32'h11);
    load(32'h44, 5'd2, 32'h22);
    load(32'h40, 5'd3, 32'h11);
    idle();
    idle();
    @(negedge clk);
`ifdef MEM_STAGE_PERF_CNT_EN
    chk("load_count", load_count, 32'd3);
    chk("store_count", store_count, 32'd2);
`else
    chk("load_count", load_count, 32'd0);
    chk("store_count", store_count, 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Latches the ALU result, Zero flag, branch target, store data and control bits into an EX/MEM register.
- Resolves branches, performs word loads and stores on an internal data memory, and presents registered MEM/WB outputs to write-back.
- Exports EX/MEM destination information to the forwarding/hazard unit.

Parameters:
- DEPTH_LOG2, 8, log2 of data memory depth in 32-bit words (default 256 words).
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- stall  input  1  hold both pipeline registers; no memory write
- flush  input  1  invalidate the instruction entering EX/MEM
- ex_valid  input  1  execute stage holds a valid instruction
- ALU_result  input  32  effective address or ALU value
- Zero  input  1  ALU zero flag
- branch_add  input  32  branch target from execute
- write_data  input  32  store data (forwarded rs2)
- rd  input  5  destination register
- MemRead, MemWrite, Branch, MemtoReg, RegWrite  input  1 each  control bits
- pcsrc  output  1  take branch: exmem_valid & Branch & Zero
- branch_target  output  32  latched branch_add
- exmem_rd  output  5  EX/MEM rd, for forwarding
- exmem_RegWrite  output  1  EX/MEM RegWrite gated by valid
- exmem_alu_result  output  32  EX/MEM ALU result, for forwarding
- wb_valid  output  1  MEM/WB holds a valid instruction
- wb_read_data  output  32  loaded word
- wb_alu_result  output  32  passed-through ALU result
- wb_rd  output  5  destination register
- wb_RegWrite, wb_MemtoReg  output  1 each  write-back controls
- misalign_err  output  1  registered misaligned-access flag
- load_count, store_count  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): every EX/MEM and MEM/WB field and every output clears to 0. Data memory contents are not reset.
- EX/MEM register, updated on each rising edge:
  - flush=1 → valid and all control bits load 0. Flush has priority over stall.
  - else stall=1 → register holds.
  - else → captures the inputs, with valid=ex_valid.
- Branch outputs:
  - pcsrc and branch_target are combinational from EX/MEM.
  - pcsrc=0 whenever EX/MEM is invalid.
- Memory index and alignment:
  - Word index is ALU_result[DEPTH_LOG2+1:2]. Addresses wrap modulo DEPTH with no range error.
  - misaligned = exmem_valid & (MemRead|MemWrite) & (addr[1:0]!=0).
- Stores:
  - Synchronous write on an edge where stall=0, exmem_valid=1, MemWrite=1 and not misaligned.
- MEM/WB register, updated when stall=0:
  - wb_valid=exmem_valid.
  - wb_read_data = mem[index] read synchronously on the same edge (read-before-write is irrelevant: only one access per cycle).
  - wb_alu_result, wb_rd and wb_MemtoReg pass through from EX/MEM.
  - wb_RegWrite = exmem_valid & RegWrite & ~misaligned.
  - misalign_err = misaligned.
  - stall=1 → MEM/WB holds.
- Latency: inputs sampled at edge N appear on wb_* after edge N+1 (2 cycles).
- Store followed immediately by a load to the same address: the load returns the new data. The write completes at the store's MEM edge, before the load reaches MEM.
- Non-memory instructions: wb_read_data is don't-care. The bench checks it only when wb_MemtoReg=1.
- A flushed instruction produces no write, no pcsrc and wb_valid=0.
- Reset mid-stall: reset dominates.

Optional Feature:
- Macro MEM_STAGE_PERF_CNT_EN.
- Defined:
  - load_count increments on each MEM-advancing edge with a valid, aligned MemRead.
  - store_count increments likewise for MemWrite.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package: DATA_W, register-index width 5, and a packed EX/MEM control struct (MemRead, MemWrite, Branch, MemtoReg, RegWrite).
- One natural sub-module: data_mem (sync write, sync read, DEPTH_LOG2 parameter).
- Pipeline registers and branch logic remain in mem_stage.

Test Plan:
- Store/load: store 0xDEADBEEF at 0x10, then load 0x10 into rd=5 → wb_read_data=0xDEADBEEF, wb_rd=5, wb_RegWrite=1, two cycles after the load.
- Branch: Branch=1, Zero=1, branch_add=0x40 → next cycle pcsrc=1, branch_target=0x40. With Zero=0 → pcsrc=0.
- Flush: flush=1 alongside a store of 0x1234 to 0x20 → a later load of 0x20 returns the old value; wb_valid=0 for that slot.
- Stall: assert stall for 3 cycles mid-stream → wb_* and exmem_* stay constant and no store commits; the sequence resumes intact.
- Misalign: store to 0x22 → memory unchanged; misalign_err=1 and wb_RegWrite=0 one cycle later.
- Reset mid-operation: pull reset_n low between edges → all outputs 0 immediately. With MEM_STAGE_PERF_CNT_EN, 3 loads + 2 stores → load_count=3, store_count=2.
